// File: rtl/delay_fifo_bram_pkg.sv
// rtl/delay_fifo_bram_pkg.sv - shared sizing constants for the reverb filter delay lines
package delay_fifo_bram_pkg;

   localparam int MAX_FILTER_FIFO_LENGTH = 8192;
   localparam int FIXED_POINT            = 16;

endpackage

// File: rtl/bram_sdp.sv
// rtl/bram_sdp.sv - simple dual-port block RAM, one write and one registered read port
module bram_sdp #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 8192,
   parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic             re,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   // Non-blocking read and write on the same edge give read-first behaviour.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
      if (re) begin
         rdata <= mem[raddr];
      end
   end

endmodule

// File: rtl/delay_fifo_bram.sv
// rtl/delay_fifo_bram.sv - programmable integer-sample delay line on a circular BRAM buffer
module delay_fifo_bram
   import delay_fifo_bram_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter int MAXLEN = MAX_FILTER_FIFO_LENGTH
) (
   input  logic             sample_clk,
   input  logic             reset,
   input  logic             enable,
   input  logic [WIDTH-1:0] len,
   input  logic [WIDTH-1:0] in,
   output logic [WIDTH-1:0] out
);

   localparam int AW  = (MAXLEN > 1) ? $clog2(MAXLEN) : 1;
   localparam int FCW = $clog2(MAXLEN + 1);
   localparam logic [FCW-1:0]          MAXLEN_F = FCW'(MAXLEN);
   localparam logic signed [WIDTH-1:0] MAXLEN_W = WIDTH'(MAXLEN);

   logic [AW-1:0]    wp_q, wp_d;
   logic [FCW-1:0]   fc_q, fc_d;
   logic             valid_q, valid_d;
   logic [FCW-1:0]   d;
   logic [FCW-1:0]   wp_ext;
   logic [FCW-1:0]   ra_ext;
   logic [AW-1:0]    ra;
   logic             adv;
   logic [WIDTH-1:0] rdata;

   always_comb begin
      d = FCW'(1);
      if (len[WIDTH-1] || (len == '0)) begin
         d = FCW'(1);
      end else if ($signed(len) >= MAXLEN_W) begin
         d = MAXLEN_F;
      end else begin
         d = len[FCW-1:0];
      end

      // Explicit wrap so non-power-of-two depths address correctly.
      wp_ext = FCW'(wp_q);
      ra_ext = (wp_ext < d) ? (wp_ext + MAXLEN_F - d) : (wp_ext - d);
      ra     = ra_ext[AW-1:0];

      wp_d    = (wp_q == AW'(MAXLEN - 1)) ? '0 : wp_q + AW'(1);
      fc_d    = (fc_q == MAXLEN_F) ? fc_q : fc_q + FCW'(1);
      valid_d = (fc_q >= d);
      adv     = enable & ~reset;
   end

   always_ff @(posedge sample_clk) begin
      if (reset) begin
         wp_q    <= '0;
         fc_q    <= '0;
         valid_q <= 1'b0;
      end else if (enable) begin
         wp_q    <= wp_d;
         fc_q    <= fc_d;
         valid_q <= valid_d;
      end
   end

   bram_sdp #(
      .WIDTH (WIDTH),
      .DEPTH (MAXLEN),
      .AW    (AW)
   ) u_ram (
      .clk   (sample_clk),
      .we    (adv),
      .waddr (wp_q),
      .wdata (in),
      .re    (adv),
      .raddr (ra),
      .rdata (rdata)
   );

   // Unwritten or stale words are hidden until the fill counter covers the delay.
   assign out = valid_q ? rdata : '0;

endmodule

// File: tb/tb_delay_fifo_bram.sv
// tb/tb_delay_fifo_bram.sv - directed self-checking bench for delay_fifo_bram
module tb_delay_fifo_bram;

   localparam int WIDTH  = 32;
   localparam int MAXLEN = 24;

   logic             clk;
   logic             reset;
   logic             enable;
   logic [WIDTH-1:0] len;
   logic [WIDTH-1:0] din;
   logic [WIDTH-1:0] dout;

   int checks;
   int errors;

   delay_fifo_bram #(
      .WIDTH  (WIDTH),
      .MAXLEN (MAXLEN)
   ) dut (
      .sample_clk (clk),
      .reset      (reset),
      .enable     (enable),
      .len        (len),
      .in         (din),
      .out        (dout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      reset  = 1'b1;
      enable = 1'b1;
      din    = 32'h777;
      tick();
      chk("reset_out", dout, '0);
      reset = 1'b0;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      reset  = 1'b0;
      enable = 1'b0;
      len    = '0;
      din    = '0;
      #2;

      // Basic delay of 4
      do_reset();
      len = 4;
      for (int k = 1; k <= 12; k++) begin
         din = WIDTH'(k);
         tick();
         chk("basic_len4", dout, (k > 4) ? WIDTH'(k - 4) : '0);
      end

      // Minimum delay, plus len=0 and len=-5 clamped to 1
      for (int t = 0; t < 3; t++) begin
         do_reset();
         len = (t == 0) ? 32'd1 : (t == 1) ? 32'd0 : -32'sd5;
         din = 32'h11; tick(); chk("min_e1", dout, 32'h00);
         din = 32'h22; tick(); chk("min_e2", dout, 32'h11);
         din = 32'h33; tick(); chk("min_e3", dout, 32'h22);
      end

      // Maximum delay across pointer wrap, len=MAXLEN and len=MAXLEN+100
      for (int t = 0; t < 2; t++) begin
         do_reset();
         len = WIDTH'(MAXLEN + 100 * t);
         for (int k = 1; k <= 3 * MAXLEN; k++) begin
            din = WIDTH'(k + 1000);
            tick();
            chk("max_wrap", dout, (k > MAXLEN) ? WIDTH'(k - MAXLEN + 1000) : '0);
         end
      end

      // Length change 8 -> 3 -> 16
      do_reset();
      len = 8;
      for (int k = 1; k <= 20; k++) begin
         din = WIDTH'(k);
         tick();
         chk("lc_len8", dout, (k > 8) ? WIDTH'(k - 8) : '0);
      end
      len = 3;
      din = 21; tick(); chk("lc_len3_a", dout, 32'd18);
      din = 22; tick(); chk("lc_len3_b", dout, 32'd19);
      len = 16;
      din = 23; tick(); chk("lc_len16_a", dout, 32'd7);
      din = 24; tick(); chk("lc_len16_b", dout, 32'd8);

      // Enable gating mid-stream
      do_reset();
      len = 4;
      for (int k = 1; k <= 8; k++) begin
         din = WIDTH'(k);
         tick();
         chk("gate_pre", dout, (k > 4) ? WIDTH'(k - 4) : '0);
      end
      enable = 1'b0;
      for (int k = 0; k < 5; k++) begin
         din = 32'd99;
         tick();
         chk("gate_hold", dout, 32'd4);
      end
      enable = 1'b1;
      for (int k = 9; k <= 14; k++) begin
         din = WIDTH'(k);
         tick();
         chk("gate_post", dout, WIDTH'(k - 4));
      end

      // Reset mid-operation masks stale RAM
      do_reset();
      len = 10;
      for (int k = 1; k <= 100; k++) begin
         din = WIDTH'(k);
         tick();
         chk("mid_pre", dout, (k > 10) ? WIDTH'(k - 10) : '0);
      end
      do_reset();
      for (int j = 1; j <= 15; j++) begin
         din = WIDTH'(500 + j);
         tick();
         chk("mid_post", dout, (j > 10) ? WIDTH'(500 + j - 10) : '0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
